// File: rtl/ram_master.sv
// ram_master: drives an asynchronous single-port RAM from a host command stream or a pattern-fill engine.
// Ports: clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata host command;
//        rsp_valid/rsp_rdata one-cycle read response; fill_start/fill_busy/fill_done pattern fill;
//        ram_addr/ram_data_in/ram_wr/ram_cs/ram_data_out RAM pins. Every output is a flop.
module ram_master #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8,
  parameter int MEM_SIZE  = 1024,
  parameter int RD_WAIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  input  logic                 fill_start,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [WORD_SIZE-1:0] ram_data_out
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_WAIT, R_CAP} state_t;
  localparam int CW = ADDR_SIZE + 1;
  localparam int WW = $clog2(RD_WAIT + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [WW-1:0] wait_cnt, wait_d;
  logic [ADDR_SIZE-1:0] ram_addr_d;
  logic [WORD_SIZE-1:0] ram_data_in_d, rsp_rdata_d;
  logic cmd_ready_d, rsp_valid_d, fill_busy_d, fill_done_d, ram_wr_d, ram_cs_d;
  logic accept_fill, accept_cmd, fill_last, fill_next;
  // fill_start wins over a simultaneous host command, which then stays pending
  assign accept_fill = state == IDLE && fill_start;
  assign accept_cmd  = state == IDLE && cmd_ready && cmd_valid && !fill_start;
  assign fill_last   = cnt == CW'(MEM_SIZE - 1);
  assign fill_next   = fill_busy && state == W_HOLD && !fill_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_wr      <= 1'b0;
      ram_cs      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      wait_cnt    <= wait_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      fill_busy   <= fill_busy_d;
      fill_done   <= fill_done_d;
      ram_addr    <= ram_addr_d;
      ram_data_in <= ram_data_in_d;
      ram_wr      <= ram_wr_d;
      ram_cs      <= ram_cs_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = accept_fill ? W_SETUP : !accept_cmd ? IDLE : cmd_wr ? W_SETUP : R_WAIT;
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD:   state_d = fill_next ? W_SETUP : IDLE;
      R_WAIT:   state_d = wait_cnt == WW'(RD_WAIT - 1) ? R_CAP : R_WAIT;
      R_CAP:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Strobes are decoded from the next state so they leave the flops aligned with the state itself
  always_comb begin
    cnt_d         = accept_fill ? '0 : fill_next ? cnt + CW'(1) : cnt;
    wait_d        = state == R_WAIT ? wait_cnt + WW'(1) : '0;
    cmd_ready_d   = state_d == IDLE;
    ram_cs_d      = state_d == W_SETUP || state_d == W_STROBE || state_d == R_WAIT;
    ram_wr_d      = state_d == W_STROBE;
    ram_addr_d    = accept_fill || fill_next ? cnt_d[ADDR_SIZE-1:0] : accept_cmd ? cmd_addr : ram_addr;
    ram_data_in_d = accept_fill || fill_next ? WORD_SIZE'({cnt_d, 1'b0}) : accept_cmd ? cmd_wdata : ram_data_in;
    fill_busy_d   = accept_fill || (fill_busy && !(state == W_HOLD && fill_last));
    fill_done_d   = fill_busy && state == W_HOLD && fill_last;
    rsp_valid_d   = state == R_WAIT && state_d == R_CAP;
    rsp_rdata_d   = rsp_valid_d ? ram_data_out : rsp_rdata;
  end
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: scoreboard bench for ram_master with RD_WAIT=1 (index 0) and RD_WAIT=3 (index 1)
module tb_ram_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid[2], cmd_ready[2], cmd_wr[2], rsp_valid[2], fill_start[2], fill_busy[2], fill_done[2], ram_wr[2], ram_cs[2];
  logic [9:0] cmd_addr[2], ram_addr[2];
  logic [7:0] cmd_wdata[2], rsp_rdata[2], ram_data_in[2], ram_data_out[2];
  logic [7:0] mem[2][1024];
  logic [7:0] exp_mem[2][1024];
  logic [7:0] sb[$];
  int vec = 0;
  int errs = 0;
  int run[2] = '{0, 0};
  logic pw[2] = '{1'b0, 1'b0};
  logic [9:0] pa[2];
  logic [7:0] pd[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_master #(.RD_WAIT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_wr(cmd_wr[g]),
      .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .fill_start(fill_start[g]), .fill_busy(fill_busy[g]), .fill_done(fill_done[g]),
      .ram_addr(ram_addr[g]), .ram_data_in(ram_data_in[g]), .ram_wr(ram_wr[g]),
      .ram_cs(ram_cs[g]), .ram_data_out(ram_data_out[g])
    );
    assign ram_data_out[g] = mem[g][ram_addr[g]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs(input int i);
    return {cmd_ready[i], rsp_valid[i], rsp_rdata[i], fill_busy[i], fill_done[i], ram_addr[i], ram_data_in[i], ram_wr[i], ram_cs[i]};
  endfunction

  // RAM model plus strobe-protocol and response monitor
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_cs[i] && ram_wr[i]) mem[i][ram_addr[i]] <= ram_data_in[i];
      if (rst_n) begin
        if (ram_wr[i]) chk("wr_needs_cs", ram_cs[i], 1);
        if (ram_wr[i] || pw[i]) begin
          chk("addr_stable", ram_addr[i], pa[i]);
          chk("data_stable", ram_data_in[i], pd[i]);
        end
        if (rsp_valid[i]) begin
          chk("cs_len", run[i], i == 0 ? 1 : 3);
          if (sb.size() == 0) chk("rsp_spurious", sb.size(), 1);
          else chk("rsp_rdata", rsp_rdata[i], sb.pop_front());
        end
        run[i] = ram_cs[i] ? run[i] + 1 : 0;
      end else run[i] = 0;
      pw[i] = rst_n && ram_wr[i];
      pa[i] = ram_addr[i];
      pd[i] = ram_data_in[i];
    end
  end

  task automatic send(input int i, input logic w, input logic [9:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid[i] = 1'b1;
    cmd_wr[i] = w;
    cmd_addr[i] = a;
    cmd_wdata[i] = d;
    while (!cmd_ready[i] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", n < 5000, 1);
    if (w) exp_mem[i][a] = d;
    else sb.push_back(exp_mem[i][a]);
    @(negedge clk);
    cmd_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_pending", sb.size(), 0);
  endtask

  task automatic fill(input int i, input bit poke, input bit pend, output int n);
    @(negedge clk);
    fill_start[i] = 1'b1;
    if (pend) begin
      cmd_valid[i] = 1'b1;
      cmd_wr[i] = 1'b0;
      cmd_addr[i] = 10'd200;
    end
    @(negedge clk);
    fill_start[i] = 1'b0;
    n = 1;
    chk("fill_busy", fill_busy[i], 1);
    for (int k = 0; k < 1024; k++) exp_mem[i][k] = 8'(2 * k);
    while (!fill_done[i] && n < 4000) begin
      fill_start[i] = poke && n == 1500;
      if (n == 1000) chk("ready_in_fill", cmd_ready[i], 0);
      @(negedge clk);
      n++;
    end
    fill_start[i] = 1'b0;
    chk("fill_busy_end", fill_busy[i], 0);
    chk("fill_ready_end", cmd_ready[i], 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_wr[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = '0; fill_start[i] = 1'b0;
    end
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cmd_valid[i] = 1'($urandom); cmd_wr[i] = 1'($urandom); cmd_addr[i] = 10'($urandom);
        cmd_wdata[i] = 8'($urandom); fill_start[i] = 1'($urandom);
        chk("reset_outs", outs(i), 0);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; fill_start[i] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset0", cmd_ready[0], 1);
    chk("ready_after_reset1", cmd_ready[1], 1);
    send(0, 1'b1, 10'h2A5, 8'h3C);
    chk("w_setup", {cmd_ready[0], ram_cs[0], ram_wr[0]}, 3'b010);
    chk("w_addr", ram_addr[0], 10'h2A5);
    chk("w_data", ram_data_in[0], 8'h3C);
    @(negedge clk);
    chk("w_strobe", {cmd_ready[0], ram_cs[0], ram_wr[0]}, 3'b011);
    @(negedge clk);
    chk("w_hold", {cmd_ready[0], ram_cs[0], ram_wr[0]}, 3'b000);
    @(negedge clk);
    chk("w_ready", cmd_ready[0], 1);
    send(0, 1'b0, 10'h2A5, 8'h00);
    drain();
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid[0], 0);
    chk("rsp_hold", rsp_rdata[0], 8'h3C);
    fill(0, 1'b1, 1'b0, n);
    chk("fill_cycles", n, 3073);
    @(negedge clk);
    chk("fill_done_pulse", fill_done[0], 0);
    send(0, 1'b0, 10'd5, 8'h00);
    send(0, 1'b0, 10'd200, 8'h00);
    send(0, 1'b0, 10'd1023, 8'h00);
    drain();
    chk("rsp_k1023", rsp_rdata[0], 8'd254);
    fill(0, 1'b0, 1'b1, n);
    chk("fill_cycles_pend", n, 3073);
    chk("pend_ready", cmd_ready[0], 1);
    sb.push_back(exp_mem[0][200]);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    chk("pend_taken", ram_cs[0], 1);
    drain();
    @(negedge clk);
    fill_start[0] = 1'b1;
    @(negedge clk);
    fill_start[0] = 1'b0;
    n = 0;
    while (!(ram_wr[0] && ram_addr[0] == 10'd10) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_k10", ram_addr[0], 10'd10);
    #2 rst_n = 1'b0;
    #1 chk("async_reset0", outs(0), 0);
    chk("async_reset1", outs(1), 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_fill_done", fill_done[0], 0);
    end
    rst_n = 1'b1;
    fill(0, 1'b0, 1'b0, n);
    chk("fill_cycles_restart", n, 3073);
    send(0, 1'b0, 10'd10, 8'h00);
    send(0, 1'b0, 10'd11, 8'h00);
    drain();
    send(1, 1'b1, 10'd0, 8'h11);
    send(1, 1'b1, 10'd1023, 8'hEE);
    send(1, 1'b0, 10'd0, 8'h00);
    send(1, 1'b0, 10'd1023, 8'h00);
    drain();
    chk("rsp_b_last", rsp_rdata[1], 8'hEE);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
